// File: rtl/pc_sequencer_if.sv
// Fetch-path bus between the decode/branch logic and the PC sequencer.
// The master drives the redirect requests; the slave (pc_sequencer) returns
// the program counter and the fetch-status flags.
interface pc_sequencer_if;
    logic               stall;
    logic               branch_taken;
    logic signed [31:0] shifted_address;
    logic               jump;
    logic        [25:0] jump_index;
    logic               jump_reg;
    logic        [31:0] reg_target;
    logic               halt;
    logic        [31:0] pc;
    logic        [31:0] pc_plus_4;
    logic               redirect;
    logic               flush;
    logic               halted;
    logic               misaligned;

    modport master (
        output stall, branch_taken, shifted_address, jump, jump_index,
               jump_reg, reg_target, halt,
        input  pc, pc_plus_4, redirect, flush, halted, misaligned
    );

    modport slave (
        input  stall, branch_taken, shifted_address, jump, jump_index,
               jump_reg, reg_target, halt,
        output pc, pc_plus_4, redirect, flush, halted, misaligned
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: forms branch/jump/jump-register targets, holds
// the architectural PC and runs the RUN/FLUSH/HALT fetch-control machine.
// The instruction fetched right after a redirect is squashed (FLUSH); a halt
// request or a misaligned register jump stops fetch until reset.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_r, pc_next;
    logic        flush_r, flush_next;
    logic        mis_r, mis_next;
    logic        redirect;
    logic [31:0] pc_plus_4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Sequential successor and candidate redirect targets, all mod 2^32.
    assign pc_plus_4     = pc_r + 32'd4;
    assign branch_target = pc_plus_4 + bus.shifted_address;
    assign jump_target   = {pc_plus_4[31:28], bus.jump_index, 2'b00};

    // Next-state, next-PC and redirect decode; priority halt > stall > jr > j > branch.
    always_comb begin
        state_next = state;
        pc_next    = pc_r;
        flush_next = flush_r;
        mis_next   = mis_r;
        redirect   = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.halt) begin
                    state_next = HALT;
                end else if (bus.stall) begin
                    state_next = RUN;
                end else if (bus.jump_reg) begin
                    if (bus.reg_target[1:0] != 2'b00) begin
                        mis_next   = 1'b1;
                        state_next = HALT;
                    end else begin
                        pc_next    = bus.reg_target;
                        redirect   = 1'b1;
                        flush_next = 1'b1;
                        state_next = FLUSH;
                    end
                end else if (bus.jump) begin
                    pc_next    = jump_target;
                    redirect   = 1'b1;
                    flush_next = 1'b1;
                    state_next = FLUSH;
                end else if (bus.branch_taken) begin
                    pc_next    = branch_target;
                    redirect   = 1'b1;
                    flush_next = 1'b1;
                    state_next = FLUSH;
                end else begin
                    pc_next = pc_plus_4;
                end
            end
            FLUSH: begin
                // Redirect requests here belong to the squashed instruction.
                if (bus.halt) begin
                    state_next = HALT;
                end else if (!bus.stall) begin
                    pc_next    = pc_plus_4;
                    flush_next = 1'b0;
                    state_next = RUN;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    // State, PC and status registers; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            pc_r    <= RESET_PC;
            flush_r <= 1'b0;
            mis_r   <= 1'b0;
        end else begin
            state   <= state_next;
            pc_r    <= pc_next;
            flush_r <= flush_next;
            mis_r   <= mis_next;
        end
    end

    assign bus.pc         = pc_r;
    assign bus.pc_plus_4  = pc_plus_4;
    assign bus.redirect   = redirect;
    assign bus.flush      = flush_r;
    assign bus.halted     = (state == HALT);
    assign bus.misaligned = mis_r;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a directed vector table walking the main fetch
// scenarios, hand sequences for asynchronous reset, then randomized traffic
// checked against a behavioural model of the PC rules.
module tb_pc_sequencer;
    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic clk;
    logic rst_n;
    pc_sequencer_if bus();

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] sa;
        logic        j;
        logic [25:0] ji;
        logic        jr;
        logic [31:0] rt;
        logic        halt;
        logic        e_red;   // redirect before the edge
        logic [31:0] e_pp4;   // pc_plus_4 before the edge
        logic [31:0] e_pc;    // after the edge
        logic        e_fl;
        logic        e_hlt;
        logic        e_mis;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_flush;
    logic        m_halted;
    logic        m_mis;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_flush = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
    endtask

    function automatic logic model_redirect(input vec_t v);
        if (m_halted || m_flush || v.halt || v.stall) return 1'b0;
        if (v.jr) return (v.rt % 4) == 0;
        return v.j || v.br;
    endfunction

    task automatic model_step(input vec_t v);
        logic [31:0] nxt, tgt;
        nxt = m_pc + 32'd4;
        if (v.jr)      tgt = v.rt;
        else if (v.j)  tgt = (nxt & 32'hF000_0000) | ({6'd0, v.ji} << 2);
        else           tgt = nxt + v.sa;
        if (m_halted) begin
        end else if (v.halt) begin
            m_halted = 1'b1;
        end else if (v.stall) begin
        end else if (m_flush) begin
            m_pc = nxt; m_flush = 1'b0;
        end else if (v.jr && (v.rt % 4) != 0) begin
            m_mis = 1'b1; m_halted = 1'b1;
        end else if (v.jr || v.j || v.br) begin
            m_pc = tgt; m_flush = 1'b1;
        end else begin
            m_pc = nxt;
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall           = v.stall;
        bus.branch_taken    = v.br;
        bus.shifted_address = v.sa;
        bus.jump            = v.j;
        bus.jump_index      = v.ji;
        bus.jump_reg        = v.jr;
        bus.reg_target      = v.rt;
        bus.halt            = v.halt;
    endtask

    // Called 1 time unit after a rising edge.
    task automatic apply_vec(input vec_t v, input string tag);
        drive(v);
        #1;
        check32({tag, " redirect"},  {31'd0, bus.redirect}, {31'd0, v.e_red});
        check32({tag, " pc_plus_4"}, bus.pc_plus_4, v.e_pp4);
        @(posedge clk);
        #1;
        check32({tag, " pc"},         bus.pc, v.e_pc);
        check32({tag, " flush"},      {31'd0, bus.flush},      {31'd0, v.e_fl});
        check32({tag, " halted"},     {31'd0, bus.halted},     {31'd0, v.e_hlt});
        check32({tag, " misaligned"}, {31'd0, bus.misaligned}, {31'd0, v.e_mis});
    endtask

    task automatic check_reset_values(input string tag);
        check32({tag, " pc"},         bus.pc, RST_PC);
        check32({tag, " pc_plus_4"},  bus.pc_plus_4, RST_PC + 32'd4);
        check32({tag, " flush"},      {31'd0, bus.flush}, 32'd0);
        check32({tag, " halted"},     {31'd0, bus.halted}, 32'd0);
        check32({tag, " misaligned"}, {31'd0, bus.misaligned}, 32'd0);
    endtask

    // Assert reset part way into a cycle, check immediately, release after the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t vecs[$];
    vec_t rv;

    initial begin
        vec_t idle;
        idle = '{1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
        drive(idle);
        rst_n = 1'b0;
        model_reset();

        //             stall br  sa            j   ji        jr  rt            halt red pp4           pc            fl  hlt mis
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'h0000_0044, 32'h0000_0044, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'h0000_0048, 32'h0000_0048, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'h0000_004C, 32'h0000_004C, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   1, 32'h0000_00FC, 0,  1, 32'h0000_0050, 32'h0000_00FC, 1, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'h0000_0100, 32'h0000_0100, 0, 0, 0});
        vecs.push_back('{0, 1, 32'hFFFF_FFF0, 0, 26'h0,   0, 32'h0,         0,  1, 32'h0000_0104, 32'h0000_00F4, 1, 0, 0});
        vecs.push_back('{0, 1, 32'hFFFF_FFF0, 0, 26'h0,   0, 32'h0,         0,  0, 32'h0000_00F8, 32'h0000_00F8, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   1, 32'h2FFF_FFFC, 0,  1, 32'h0000_00FC, 32'h2FFF_FFFC, 1, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'h3000_0000, 32'h3000_0000, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         1, 26'h100, 0, 32'h0,         0,  1, 32'h3000_0004, 32'h3000_0400, 1, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   1, 32'h2FFF_FFFC, 0,  0, 32'h3000_0404, 32'h3000_0404, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   1, 32'h2FFF_FFFC, 0,  1, 32'h3000_0408, 32'h2FFF_FFFC, 1, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'h3000_0000, 32'h3000_0000, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         1, 26'h100, 1, 32'h0000_0200, 0,  1, 32'h3000_0004, 32'h0000_0200, 1, 0, 0});
        vecs.push_back('{1, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'h0000_0204, 32'h0000_0200, 1, 0, 0});
        vecs.push_back('{1, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'h0000_0204, 32'h0000_0200, 1, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'h0000_0204, 32'h0000_0204, 0, 0, 0});
        vecs.push_back('{1, 1, 32'h40,        0, 26'h0,   0, 32'h0,         0,  0, 32'h0000_0208, 32'h0000_0204, 0, 0, 0});
        vecs.push_back('{1, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'h0000_0208, 32'h0000_0204, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'h0000_0208, 32'h0000_0208, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   1, 32'hFFFF_FFF8, 0,  1, 32'h0000_020C, 32'hFFFF_FFF8, 1, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   0, 32'h0,         0,  0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   1, 32'h0000_1002, 0,  0, 32'h0000_0004, 32'h0000_0000, 0, 1, 1});
        vecs.push_back('{0, 1, 32'h10,        1, 26'h5,   1, 32'h0000_0100, 0,  0, 32'h0000_0004, 32'h0000_0000, 0, 1, 1});
        vecs.push_back('{0, 0, 32'h0,         0, 26'h0,   0, 32'h0,         1,  0, 32'h0000_0004, 32'h0000_0000, 0, 1, 1});

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while halted clears everything without a clock edge.
        async_reset("rst_in_halt");

        // Reset while in FLUSH.
        rv = idle; rv.jr = 1'b1; rv.rt = 32'h0000_0800;
        rv.e_red = 1'b1; rv.e_pp4 = RST_PC + 32'd4; rv.e_pc = 32'h0000_0800; rv.e_fl = 1'b1;
        apply_vec(rv, "flush_setup");
        async_reset("rst_in_flush");

        // Halt during FLUSH: fetch stops, PC stays.
        rv = idle; rv.j = 1'b1; rv.ji = 26'h40;
        rv.e_red = 1'b1; rv.e_pp4 = RST_PC + 32'd4; rv.e_pc = 32'h0000_0100; rv.e_fl = 1'b1;
        apply_vec(rv, "flush_halt_a");
        rv = idle; rv.halt = 1'b1; rv.stall = 1'b1; rv.br = 1'b1;
        rv.e_pp4 = 32'h0000_0104; rv.e_pc = 32'h0000_0100; rv.e_fl = 1'b1; rv.e_hlt = 1'b1;
        apply_vec(rv, "flush_halt_b");
        async_reset("rst_after_halt");

        // Randomized traffic against the behavioural model.
        for (int n = 0; n < 1500; n++) begin
            if (m_halted && ($urandom_range(0, 2) == 0)) begin
                async_reset("rst_rand");
            end else if ($urandom_range(0, 199) == 0) begin
                async_reset("rst_rand_mid");
            end else begin
                rv = idle;
                rv.stall = ($urandom_range(0, 4) == 0);
                rv.halt  = ($urandom_range(0, 59) == 0);
                rv.jr    = ($urandom_range(0, 5) == 0);
                rv.j     = ($urandom_range(0, 3) == 0);
                rv.br    = ($urandom_range(0, 2) == 0);
                rv.ji    = 26'($urandom);
                rv.rt    = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 7) == 0) rv.rt[1:0] = 2'($urandom_range(1, 3));
                rv.sa    = 32'($signed(16'($urandom))) <<< 2;
                rv.e_red = model_redirect(rv);
                rv.e_pp4 = m_pc + 32'd4;
                model_step(rv);
                rv.e_pc  = m_pc;
                rv.e_fl  = m_flush;
                rv.e_hlt = m_halted;
                rv.e_mis = m_mis;
                apply_vec(rv, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
